// File: rtl/s_fflopnvar.sv
// rtl/s_fflopnvar.sv - variable-depth delay line with per-stage valid bits.
// Occupancy counter is built only when S_FFLOPNVAR_OCC_EN is defined; otherwise occ is tied to 0.
module s_fflopnvar #(
  parameter int              SIZE    = 8,
  parameter int              MAXDLY  = 8,
  parameter int              DLYW    = 4,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DLYW-1:0] dly,
  input  logic            vi,
  input  logic [SIZE-1:0] d,
  output logic            vo,
  output logic [SIZE-1:0] qn,
  output logic [DLYW-1:0] occ,
  output logic            dly_err
);

  localparam logic [DLYW-1:0] MAXDLY_W = DLYW'(MAXDLY);

  logic [SIZE-1:0]   r_s [MAXDLY];
  logic [MAXDLY-1:0] r_v;
  logic [DLYW-1:0]   r_dly_q;

  logic [DLYW-1:0]   w_de;
  logic              w_chg;
  logic [SIZE-1:0]   w_stap;
  logic              w_vtap;

  assign dly_err = (dly > MAXDLY_W);
  assign w_de    = dly_err ? MAXDLY_W : dly;
  assign w_chg   = (dly != r_dly_q);

  // Tap select by comparison keeps the mux free of out-of-range indexing; de=0 is the bypass.
  always_comb begin
    w_stap = d;
    w_vtap = vi;
    for (int k = 0; k < MAXDLY; k++) begin
      if (w_de == DLYW'(k + 1)) begin
        w_stap = r_s[k];
        w_vtap = r_v[k];
      end
    end
  end

  assign qn = w_stap;
  assign vo = w_vtap & ~w_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAXDLY; k++) r_s[k] <= RST_VAL;
    end else if (en) begin
      r_s[0] <= d;
      for (int k = 1; k < MAXDLY; k++) r_s[k] <= r_s[k-1];
    end
  end

  // A delay change flushes every in-flight valid so no entry leaves at the wrong latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v     <= '0;
      r_dly_q <= '0;
    end else begin
      r_dly_q <= dly;
      if (w_chg) begin
        r_v <= '0;
      end else if (en) begin
        r_v[0] <= vi;
        for (int k = 1; k < MAXDLY; k++) r_v[k] <= r_v[k-1];
      end
    end
  end

`ifdef S_FFLOPNVAR_OCC_EN
  logic [DLYW-1:0] r_occ;

  always_ff @(posedge clk) begin
    if (rst || w_chg || (w_de == '0)) begin
      r_occ <= '0;
    end else if (en) begin
      r_occ <= r_occ + DLYW'(vi) - DLYW'(w_vtap);
    end
  end

  assign occ = r_occ;
`else
  assign occ = '0;
`endif

endmodule
